csr_machine_gen: RTL and testbench
==================================

// Module: csr_machine_gen
// PURPOSE
//  Parametrised machine-mode CSR unit for the RV32/RV64 core: mstatus/misa/mie/mip/mtvec/mscratch/mepc/mcause/mtval,
//  64-bit mcycle/minstret, NUM_HPM event-driven hpm counters, mcountinhibit, and NUM_LIRQ local interrupts.
//  Sits beside the execute stage. Reads are combinational in decode; writes, traps and mret are taken from execute.
//  Generalises the fixed RV32 CSR block with a width parameter, hpm counters, local IRQs and correct vectored traps.
// PARAMETERS
//  XLEN       32        register width, 32 or 64; counters are always 64 bit
//  NUM_HPM    4         mhpmcounter3.. / mhpmevent3.. implemented (0..29); the rest read 0, writes ignored
//  NUM_EVT    8         width of evt input vector (1..31)
//  NUM_LIRQ   4         local interrupts at mip/mie bits 16..16+NUM_LIRQ-1 (0..16)
//  MTVEC_RST  0         reset value of mtvec
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous reset, active-low
//  rden       in   1         decode read enable
//  raddr      in   12        decode read address
//  rdata      out  XLEN      read data; 0 if rden=0 or address unimplemented
//  wren       in   1         execute write enable (already-computed csrrw/s/c result)
//  waddr      in   12        execute write address
//  wdata      in   XLEN      execute write data
//  valid      in   1         instruction retires this cycle (instret + interrupt boundary)
//  exc        in   1         synchronous exception
//  ecause     in   5         exception code
//  epc        in   XLEN      pc of faulting/interrupted instruction
//  etval      in   XLEN      trap value
//  mret       in   1         mret executes
//  meip/mtip/msip in 1 each  external/timer/software interrupt levels
//  lirq       in   NUM_LIRQ  local interrupt levels
//  evt        in   NUM_EVT   per-cycle hpm event strobes
//  trap       out  1         registered: trap taken last cycle, redirect to trap_vec
//  trap_vec   out  XLEN      combinational trap target
//  mret_o     out  1         registered: mret completed last cycle, redirect to mepc_o
//  mepc_o     out  XLEN      current mepc, bits[1:0] forced 0
//  irq_pend   out  1         combinational: mstatus.MIE & |(mip & mie)
// BEHAVIOUR
//  Reset: all CSRs 0 except mstatus.MPP=2'b11, mtvec=MTVEC_RST, misa=const (MXL per XLEN, I,M); trap=mret_o=0.
//  Interrupt inputs register one cycle into mip (read-only, writes ignored); mip/mie bits above implemented set read 0.
//  mstatus: only MIE(3), MPIE(7) writable; MPP hardwired 11; other bits read 0.
//  mtvec: mode field WARL {0,1}; a write of 2/3 keeps the old mode. BASE bits[XLEN-1:2].
//  Counters: mcycle+1 per clk unless mcountinhibit[0]; minstret+valid unless [2];
//   hpm i (3..): +1 when mhpmevent[i]=k, 1<=k<=NUM_EVT, evt[k-1]=1 and not inhibit[i]; k=0 or >NUM_EVT never counts.
//   64-bit wrap to 0. XLEN=32: low/high halves at 0xB00+/0xB80+ (and 0xB02/0xB82), writing one half keeps the other.
//   A CSR write to a counter wins over its increment in the same cycle.
//  Trap accept (cycle N): exc=1, else valid=1 & MIE & (mip&mie)!=0. Priority exc > MEI(11) > MSI(3) > MTI(7) > lirq[0..].
//   On accept: mepc<=epc, mtval<=etval (0 for interrupts), mcause<={int,code}, int at bit XLEN-1, MPIE<=MIE, MIE<=0;
//   trap=1 in cycle N+1 only. trap_vec=BASE<<2; vectored mode & interrupt cause: +4*code; exceptions never offset.
//  mret (no trap in same cycle): MIE<=MPIE, MPIE<=1; mret_o=1 in N+1. exc with mret same cycle: trap wins, mret dropped.
//  Trap/mret field updates win over a simultaneous wren to mstatus/mepc/mcause/mtval; other wren fields still apply.
//  Async reset mid-operation clears pending trap/mret_o pulses immediately; no partial trap is retained.
// TESTING
//  Reset, read misa/mstatus/mtvec -> misa const, mstatus=0x1800, mtvec=MTVEC_RST, trap=mret_o=0.
//  mie=0x808, MIE=1, meip=msip=1, valid=1 -> trap next cycle, mcause=0x8000000B, MIE=0, MPIE=1.
//  mtvec=0x101, lirq[1] enabled and pending -> trap_vec=0x100+4*17=0x144; exc ecause=2 -> trap_vec=0x100.
//  mhpmevent3=2, evt[1] high 10 cycles, inhibit[3] set 4 of them -> mhpmcounter3=6; mhpmevent3=9 (>NUM_EVT) -> no count.
//  XLEN=32: mcycle low=0xFFFFFFFF, high=0 -> next cycle low=0, high=1; write mcycle same cycle -> written value kept.
//  exc+mret+wren(mepc) same cycle -> mepc=epc, trap=1, mret_o=0; rst low mid-trap -> trap=0 immediately.

Source files
------------

// File: rtl/csr_machine_gen_if.sv
// Signal bundle between the execute/decode stages and the machine-mode CSR unit.
// Handshake: every strobe is single-cycle and unconditionally accepted; there is no ready/backpressure.
interface csr_machine_gen_if #(
  parameter int XLEN     = 32,
  parameter int NUM_EVT  = 8,
  parameter int NUM_LIRQ = 4
);
  localparam int LW = (NUM_LIRQ > 0) ? NUM_LIRQ : 1;

  logic              rden;
  logic [11:0]       raddr;
  logic [XLEN-1:0]   rdata;
  logic              wren;
  logic [11:0]       waddr;
  logic [XLEN-1:0]   wdata;
  logic              valid;
  logic              exc;
  logic [4:0]        ecause;
  logic [XLEN-1:0]   epc;
  logic [XLEN-1:0]   etval;
  logic              mret;
  logic              meip;
  logic              mtip;
  logic              msip;
  logic [LW-1:0]     lirq;
  logic [NUM_EVT-1:0] evt;
  logic              trap;
  logic [XLEN-1:0]   trap_vec;
  logic              mret_o;
  logic [XLEN-1:0]   mepc_o;
  logic              irq_pend;

  modport slave (
    input  rden, raddr, wren, waddr, wdata, valid, exc, ecause, epc, etval, mret,
           meip, mtip, msip, lirq, evt,
    output rdata, trap, trap_vec, mret_o, mepc_o, irq_pend
  );

  modport master (
    output rden, raddr, wren, waddr, wdata, valid, exc, ecause, epc, etval, mret,
           meip, mtip, msip, lirq, evt,
    input  rdata, trap, trap_vec, mret_o, mepc_o, irq_pend
  );
endinterface

// File: rtl/csr_machine_gen.sv
// Machine-mode CSR unit: trap/mret sequencing, interrupt pending logic, 64-bit cycle/instret/hpm counters.
// Reads are combinational; writes, traps and mret take effect on the clock edge.
module csr_machine_gen #(
  parameter int          XLEN      = 32,
  parameter int          NUM_HPM   = 4,
  parameter int          NUM_EVT   = 8,
  parameter int          NUM_LIRQ  = 4,
  parameter logic [63:0] MTVEC_RST = 64'h0
) (
  input logic              clk,
  input logic              rst,
  csr_machine_gen_if.slave bus
);
  localparam logic [1:0]  MXL       = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h0000_1100);
  localparam logic [31:0] IRQ_MASK  = 32'h0000_0888 | (((32'h1 << NUM_LIRQ) - 32'h1) << 16);
  localparam logic [31:0] INH_MASK  = 32'h0000_0005 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic [31:0]       mie_q, mip_q, inhibit;
  logic              st_mie, st_mpie;
  logic [XLEN-1:2]   tvec_base;
  logic              tvec_mode;
  logic [XLEN-1:0]   mscratch, mepc, mcause, mtval;
  logic [63:0]       mcycle, minstret;
  logic [63:0]       hpm_cnt [29];
  logic [XLEN-1:0]   hpm_evt [29];
  logic              trap_q, mret_q;

  logic [31:0]       mip_in, pend, evt_ext;
  logic [4:0]        irq_code;
  logic              irq_take, trap_take, mret_take;
  logic [XLEN-1:0]   cause_n, mstatus_r;

  function automatic logic wr_lo(input logic [11:0] a);
    return bus.wren && (bus.waddr == a);
  endfunction

  function automatic logic wr_hi(input logic [11:0] a);
    return (XLEN == 32) && bus.wren && (bus.waddr == a);
  endfunction

  // Merge a CSR write into a 64-bit counter; on RV32 only the addressed half changes.
  function automatic logic [63:0] cnt_wr(input logic [63:0] old, input logic hi,
                                         input logic [XLEN-1:0] d);
    logic [63:0] dx;
    dx = 64'(d);
    if (XLEN == 64) return dx;
    if (hi) return {dx[31:0], old[31:0]};
    return {old[63:32], dx[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] cnt_hi(input logic [63:0] c);
    return XLEN'(c >> 32);
  endfunction

  function automatic logic evt_hit(input logic [XLEN-1:0] k, input logic [31:0] e);
    if (k == '0 || k > XLEN'(NUM_EVT)) return 1'b0;
    return e[k[4:0] - 5'd1];
  endfunction

  always_comb begin
    mip_in = ((32'(bus.lirq) << 16) & IRQ_MASK)
           | {20'b0, bus.meip, 3'b0, bus.mtip, 3'b0, bus.msip, 3'b0};
    evt_ext = 32'(bus.evt);
    pend    = mip_q & mie_q;
    // Lowest local IRQ index wins among locals; then MTI < MSI < MEI overrides.
    irq_code = 5'd0;
    for (int i = 31; i >= 16; i--)
      if (pend[i]) irq_code = 5'(i);
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
    irq_take  = bus.valid && st_mie && (pend != 32'h0);
    trap_take = bus.exc || irq_take;
    mret_take = bus.mret && !trap_take;
    cause_n   = bus.exc ? XLEN'(bus.ecause)
                        : ({1'b1, {(XLEN-1){1'b0}}} | XLEN'(irq_code));
    mstatus_r = XLEN'({2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q     <= '0;
      mip_q     <= '0;
      inhibit   <= '0;
      st_mie    <= 1'b0;
      st_mpie   <= 1'b0;
      tvec_base <= MTVEC_RST[XLEN-1:2];
      tvec_mode <= MTVEC_RST[0];
      mscratch  <= '0;
      mepc      <= '0;
      mcause    <= '0;
      mtval     <= '0;
      mcycle    <= '0;
      minstret  <= '0;
      for (int i = 0; i < 29; i++) begin
        hpm_cnt[i] <= '0;
        hpm_evt[i] <= '0;
      end
      trap_q    <= 1'b0;
      mret_q    <= 1'b0;
    end else begin
      mip_q  <= mip_in;
      trap_q <= trap_take;
      mret_q <= mret_take;
      if (wr_lo(12'h304)) mie_q   <= 32'(bus.wdata) & IRQ_MASK;
      if (wr_lo(12'h320)) inhibit <= 32'(bus.wdata) & INH_MASK;
      if (wr_lo(12'h340)) mscratch <= bus.wdata;
      if (wr_lo(12'h305)) begin
        tvec_base <= bus.wdata[XLEN-1:2];
        if (!bus.wdata[1]) tvec_mode <= bus.wdata[0];
      end
      if (trap_take) begin
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_take) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_lo(12'h300)) begin
        st_mie  <= bus.wdata[3];
        st_mpie <= bus.wdata[7];
      end
      if (trap_take) begin
        mepc   <= {bus.epc[XLEN-1:2], 2'b00};
        mcause <= cause_n;
        mtval  <= bus.exc ? bus.etval : '0;
      end else begin
        if (wr_lo(12'h341)) mepc   <= {bus.wdata[XLEN-1:2], 2'b00};
        if (wr_lo(12'h342)) mcause <= bus.wdata;
        if (wr_lo(12'h343)) mtval  <= bus.wdata;
      end
      if (wr_lo(12'hB00))      mcycle <= cnt_wr(mcycle, 1'b0, bus.wdata);
      else if (wr_hi(12'hB80)) mcycle <= cnt_wr(mcycle, 1'b1, bus.wdata);
      else if (!inhibit[0])    mcycle <= mcycle + 64'd1;
      if (wr_lo(12'hB02))      minstret <= cnt_wr(minstret, 1'b0, bus.wdata);
      else if (wr_hi(12'hB82)) minstret <= cnt_wr(minstret, 1'b1, bus.wdata);
      else if (!inhibit[2] && bus.valid) minstret <= minstret + 64'd1;
      for (int i = 0; i < 29; i++) begin
        if (i < NUM_HPM) begin
          if (wr_lo(12'(12'h323 + i))) hpm_evt[i] <= bus.wdata;
          if (wr_lo(12'(12'hB03 + i)))      hpm_cnt[i] <= cnt_wr(hpm_cnt[i], 1'b0, bus.wdata);
          else if (wr_hi(12'(12'hB83 + i))) hpm_cnt[i] <= cnt_wr(hpm_cnt[i], 1'b1, bus.wdata);
          else if (!inhibit[i+3] && evt_hit(hpm_evt[i], evt_ext))
            hpm_cnt[i] <= hpm_cnt[i] + 64'd1;
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rden) begin
      case (bus.raddr)
        12'h300: bus.rdata = mstatus_r;
        12'h301: bus.rdata = MISA_VAL;
        12'h304: bus.rdata = XLEN'(mie_q);
        12'h305: bus.rdata = {tvec_base, 1'b0, tvec_mode};
        12'h320: bus.rdata = XLEN'(inhibit);
        12'h340: bus.rdata = mscratch;
        12'h341: bus.rdata = mepc;
        12'h342: bus.rdata = mcause;
        12'h343: bus.rdata = mtval;
        12'h344: bus.rdata = XLEN'(mip_q);
        12'hB00: bus.rdata = XLEN'(mcycle);
        12'hB02: bus.rdata = XLEN'(minstret);
        12'hB80: if (XLEN == 32) bus.rdata = cnt_hi(mcycle);
        12'hB82: if (XLEN == 32) bus.rdata = cnt_hi(minstret);
        default: begin
          for (int i = 0; i < 29; i++) begin
            if (i < NUM_HPM) begin
              if (bus.raddr == 12'(12'h323 + i)) bus.rdata = hpm_evt[i];
              if (bus.raddr == 12'(12'hB03 + i)) bus.rdata = XLEN'(hpm_cnt[i]);
              if ((XLEN == 32) && (bus.raddr == 12'(12'hB83 + i))) bus.rdata = cnt_hi(hpm_cnt[i]);
            end
          end
        end
      endcase
    end
  end

  // Only interrupt causes are offset in vectored mode; exceptions always go to BASE.
  always_comb begin
    bus.trap_vec = {tvec_base, 2'b00};
    if (tvec_mode && mcause[XLEN-1])
      bus.trap_vec = {tvec_base, 2'b00} + XLEN'({mcause[4:0], 2'b00});
    bus.trap     = trap_q;
    bus.mret_o   = mret_q;
    bus.mepc_o   = mepc;
    bus.irq_pend = st_mie && ((mip_q & mie_q) != 32'h0);
  end
endmodule

// File: tb/tb_csr_machine_gen.sv
// Directed bench for csr_machine_gen (RV32 configuration) with a queue-based scoreboard.
module tb_csr_machine_gen;
  localparam int K_RD = 0, K_TM = 1, K_TVEC = 2, K_IRQ = 3, K_MEPC = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic obs   = 1'b0;
  logic [63:0] exp_q[$];
  int          kind_q[$];

  csr_machine_gen_if #(.XLEN(32), .NUM_EVT(8), .NUM_LIRQ(4)) bus ();

  csr_machine_gen #(
    .XLEN(32), .NUM_HPM(4), .NUM_EVT(8), .NUM_LIRQ(4), .MTVEC_RST(64'h80)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "rdata";
      K_TM:    return "mret_o_trap";
      K_TVEC:  return "trap_vec";
      K_IRQ:   return "irq_pend";
      default: return "mepc_o";
    endcase
  endfunction

  // monitor: pops the expected value whenever a response is presented
  always @(negedge clk) begin
    if (obs) begin
      logic [63:0] act, e;
      int k;
      if (exp_q.size() == 0 || kind_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got empty queue want an entry");
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        case (k)
          K_RD:    act = 64'(bus.rdata);
          K_TM:    act = 64'({bus.mret_o, bus.trap});
          K_TVEC:  act = 64'(bus.trap_vec);
          K_IRQ:   act = 64'(bus.irq_pend);
          default: act = 64'(bus.mepc_o);
        endcase
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s (addr %h): got %h want %h", kname(k), bus.raddr, act, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.wren  = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    tick();
    bus.wren  = 1'b0;
  endtask

  task automatic chk(input int k, input logic [63:0] e);
    kind_q.push_back(k);
    exp_q.push_back(e);
    obs = 1'b1;
    @(negedge clk);
    #1;
    obs = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    bus.rden  = 1'b1;
    bus.raddr = a;
    chk(K_RD, 64'(e));
    bus.rden  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.rden = 0; bus.raddr = '0; bus.wren = 0; bus.waddr = '0; bus.wdata = '0;
    bus.valid = 0; bus.exc = 0; bus.ecause = '0; bus.epc = '0; bus.etval = '0;
    bus.mret = 0; bus.meip = 0; bus.mtip = 0; bus.msip = 0; bus.lirq = '0; bus.evt = '0;

    // reset values
    chk(K_TM, 64'h0);
    tick();
    rst = 1'b1;
    rd(12'h301, 32'h4000_1100);
    rd(12'h300, 32'h0000_1800);
    rd(12'h305, 32'h0000_0080);
    rd(12'h304, 32'h0);
    chk(K_TM, 64'h0);

    // MEI taken over MSI, interrupt trap bookkeeping
    bus.meip = 1; bus.msip = 1;
    wr(12'h304, 32'h808);
    wr(12'h300, 32'h8);
    chk(K_IRQ, 64'h1);
    bus.epc = 32'h1234; bus.etval = 32'hdead; bus.valid = 1;
    tick();
    bus.valid = 0;
    chk(K_TM, 64'h1);
    chk(K_TVEC, 64'h80);
    rd(12'h342, 32'h8000_000B);
    rd(12'h300, 32'h0000_1880);
    rd(12'h341, 32'h1234);
    rd(12'h343, 32'h0);
    chk(K_IRQ, 64'h0);
    rd(12'h344, 32'h808);
    wr(12'h344, 32'h0);
    rd(12'h344, 32'h808);
    bus.meip = 0; bus.msip = 0;

    // mret restores MIE from MPIE
    bus.mret = 1;
    tick();
    bus.mret = 0;
    chk(K_TM, 64'h2);
    rd(12'h300, 32'h0000_1888);
    chk(K_MEPC, 64'h1234);

    // MSI beats MTI
    bus.msip = 1; bus.mtip = 1;
    wr(12'h304, 32'h88);
    bus.valid = 1;
    tick();
    bus.valid = 0;
    chk(K_TM, 64'h1);
    rd(12'h342, 32'h8000_0003);
    bus.msip = 0; bus.mtip = 0;

    // mtvec WARL mode and vectored targets
    wr(12'h305, 32'h101);
    rd(12'h305, 32'h101);
    wr(12'h305, 32'h202);
    rd(12'h305, 32'h201);
    wr(12'h305, 32'h101);
    wr(12'h304, 32'h2_0000);
    bus.lirq = 4'b0010;
    wr(12'h300, 32'h8);
    bus.valid = 1;
    tick();
    bus.valid = 0;
    chk(K_TVEC, 64'h144);
    rd(12'h342, 32'h8000_0011);
    bus.lirq = '0;
    bus.exc = 1; bus.ecause = 5'd2; bus.epc = 32'h500; bus.etval = 32'h77;
    tick();
    bus.exc = 0;
    chk(K_TVEC, 64'h100);
    rd(12'h342, 32'h2);
    rd(12'h343, 32'h77);
    rd(12'h341, 32'h500);

    // hpm3 counting with inhibit, then an out-of-range selector
    wr(12'h320, 32'h8);
    wr(12'h323, 32'h2);
    wr(12'hB03, 32'h0);
    bus.evt = 8'h02;
    repeat (3) tick();
    wr(12'h320, 32'h0);
    repeat (6) tick();
    bus.evt = 8'h00;
    rd(12'hB03, 32'd6);
    wr(12'h323, 32'h9);
    bus.evt = 8'hFF;
    repeat (5) tick();
    bus.evt = 8'h00;
    rd(12'hB03, 32'd6);
    rd(12'hB83, 32'd0);
    rd(12'h323, 32'h9);

    // mcycle carry across halves, write beats increment
    wr(12'h320, 32'h1);
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    rd(12'hB80, 32'h0);
    wr(12'h320, 32'h0);
    rd(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'h0);
    rd(12'hB80, 32'h1);
    wr(12'hB00, 32'h100);
    rd(12'hB00, 32'h100);
    wr(12'h320, 32'h1);

    // exc + mret + mepc write in one cycle: trap wins
    bus.exc = 1; bus.ecause = 5'd5; bus.epc = 32'h600; bus.mret = 1;
    bus.wren = 1; bus.waddr = 12'h341; bus.wdata = 32'h999;
    tick();
    bus.exc = 0; bus.mret = 0; bus.wren = 0;
    chk(K_TM, 64'h1);
    rd(12'h341, 32'h600);
    rd(12'h342, 32'h5);

    // reset in the middle of a trap pulse
    bus.exc = 1; bus.ecause = 5'd7;
    tick();
    bus.exc = 0;
    #1;
    rst = 1'b0;
    chk(K_TM, 64'h0);
    rd(12'h342, 32'h0);
    tick();
    rst = 1'b1;
    rd(12'h300, 32'h0000_1800);
    rd(12'h305, 32'h0000_0080);

    // final report
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
